uart_byte_tx: RTL

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_cnt.sv | 44 ++++
 rtl/uart_byte_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_pkg;

   // 50 MHz / 9600 baud
   localparam int unsigned DefaultBaudDiv = 5208;

   // Bits on the line per frame: start + 8 data + stop, optionally + parity
   localparam int unsigned FrameBitsNoParity = 10;
   localparam int unsigned FrameBitsParity   = 11;

`ifdef UART_TX_PARITY_EN
   localparam int unsigned FrameBits = FrameBitsParity;
`else
   localparam int unsigned FrameBits = FrameBitsNoParity;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DefaultBaudDiv
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end,
   output logic bit_end_next
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: held at zero while cleared, wraps at the end of each bit period
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign bit_end      = (cnt_q == CntMax);
   // Lets the sequencer register a pulse that lines up with the coming last cycle
   assign bit_end_next = (cnt_d == CntMax);

   // Counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Optional one-entry holding register (HOLD_EN) lets the next byte start with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN (inserts the parity bit after the data bits).
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DefaultBaudDiv,
   parameter int unsigned HOLD_EN  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       busy,
   output logic       pend,
   output logic       done,
   output logic       ovf
);

   tx_state_e  state_q;
   logic [7:0] shift_q;
   logic [7:0] hold_q;
   logic [2:0] bit_cnt_q;
`ifdef UART_TX_PARITY_EN
   logic       par_q;
`endif

   logic       baud_clear;
   logic       bit_end;
   logic       bit_end_next;
   logic       handover;
   logic [7:0] start_byte;

   // Every non-idle state is entered on a bit_end, where the counter wraps to zero anyway,
   // so holding it clear in idle is enough to start each state from zero.
   assign baud_clear = (state_q == StIdle);
   // Last cycle of the stop bit: the next frame may start on the following edge
   assign handover   = (state_q == StStop) && bit_end;
   // A held byte always goes before a byte arriving in the same cycle
   assign start_byte = pend ? hold_q : tx_data;

   uart_baud_cnt #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (baud_clear),
      .bit_end      (bit_end),
      .bit_end_next (bit_end_next)
   );

   // Frame sequencer with registered line, status flags and holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         hold_q    <= '0;
         bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
         tx        <= 1'b1;
         busy      <= 1'b0;
         pend      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tx_en) begin
                  state_q   <= StStart;
                  shift_q   <= tx_data;
`ifdef UART_TX_PARITY_EN
                  par_q     <= ^tx_data;
`endif
                  bit_cnt_q <= '0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q   <= StData;
                  bit_cnt_q <= '0;
                  tx        <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
               end
            end
            StData: begin
               if (bit_end) begin
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q   <= StParity;
                     tx        <= par_q;
`else
                     state_q   <= StStop;
                     tx        <= 1'b1;
                     done      <= bit_end_next;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     tx        <= shift_q[0];
                     shift_q   <= {1'b0, shift_q[7:1]};
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state_q   <= StStop;
                  bit_cnt_q <= '0;
                  tx        <= 1'b1;
                  done      <= bit_end_next;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  if (pend || tx_en) begin
                     // Back-to-back frame: no idle cycle between stop and start
                     state_q   <= StStart;
                     shift_q   <= start_byte;
`ifdef UART_TX_PARITY_EN
                     par_q     <= ^start_byte;
`endif
                     bit_cnt_q <= '0;
                     tx        <= 1'b0;
                     if (pend && tx_en) begin
                        hold_q <= tx_data;
                     end else begin
                        pend   <= 1'b0;
                     end
                  end else begin
                     state_q <= StIdle;
                     busy    <= 1'b0;
                  end
               end else begin
                  done <= bit_end_next;
               end
            end
            default: begin
               state_q <= StIdle;
               tx      <= 1'b1;
               busy    <= 1'b0;
            end
         endcase

         // Requests arriving mid-frame go to the holding register or are dropped
         if (tx_en && !baud_clear && !handover) begin
            if ((HOLD_EN != 0) && !pend) begin
               hold_q <= tx_data;
               pend   <= 1'b1;
            end else begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule
